// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the tiny MIPS hazard/stall sequencer.
package hazard_stall_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    DBG_RUN  = 2'b00,
    DBG_HALT = 2'b01,
    DBG_STEP = 2'b10
  } dbg_state_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
  } sb_slot_t;

  // $0 is hardwired, so a read of it can never depend on an in-flight write.
  function automatic logic src_match(input logic use_src,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input sb_slot_t slot);
    return use_src && slot.valid && (src == slot.rd) && (src != ZERO_REG);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle between the ID/EX datapath and the stall controller.
interface hazard_stall_ctrl_if #(parameter int CNT_W = 16);
  import hazard_stall_ctrl_pkg::*;

  // Handshake: the instruction in ID is consumed on a cycle with id_valid=1 and
  // de_bubble=0 (fd_we=1 at the same time); on any other cycle ID must hold it.
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_use_rs;
  logic                  id_use_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  ex_branch_taken;
  logic                  dbg_halt_req;
  logic                  dbg_step_req;
  logic                  dbg_resume;
  logic                  pc_we;
  logic                  fd_we;
  logic                  fd_flush;
  logic                  de_bubble;
  logic [1:0]            dbg_state;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_reg_write,
           ex_branch_taken, dbg_halt_req, dbg_step_req, dbg_resume,
    input  pc_we, fd_we, fd_flush, de_bubble, dbg_state, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_reg_write,
           ex_branch_taken, dbg_halt_req, dbg_step_req, dbg_resume,
    output pc_we, fd_we, fd_flush, de_bubble, dbg_state, stall_cnt
  );

endinterface

// File: rtl/hazard_stall_ctrl_scoreboard.sv
// In-flight destination tracker: one slot per stage after ID, shifted every cycle.
module hazard_stall_ctrl_scoreboard
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int SB_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  output logic                  hazard
);

  sb_slot_t slots [SB_DEPTH];
  logic     any_match;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < SB_DEPTH; k++) begin
        slots[k] <= '0;
      end
    end else begin
      if (issue) begin
        slots[0].valid <= id_reg_write && (id_rd != ZERO_REG);
        slots[0].rd    <= id_rd;
      end else begin
        slots[0] <= '0;
      end
      for (int k = 1; k < SB_DEPTH; k++) begin
        slots[k] <= slots[k-1];
      end
    end
  end

  always_comb begin
    any_match = 1'b0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      if (src_match(id_use_rs, id_rs, slots[k]) || src_match(id_use_rt, id_rt, slots[k])) begin
        any_match = 1'b1;
      end
    end
  end

  assign hazard = id_valid && any_match;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: RAW stall/bubble control, branch flush, debug run/halt/step FSM
// and a saturating count of hazard-stall cycles.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int SB_DEPTH = 3,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_stall_ctrl_if.slave bus
);

  dbg_state_e       state, state_nxt;
  logic             hazard;
  logic             issue;
  logic             can_issue;
  logic [CNT_W-1:0] stall_cnt;

  assign can_issue = (state == DBG_RUN) || (state == DBG_STEP);
  assign issue     = bus.id_valid && !hazard && !bus.ex_branch_taken && can_issue;

  hazard_stall_ctrl_scoreboard #(.SB_DEPTH(SB_DEPTH)) u_sb (
    .clk          (clk),
    .rst          (rst),
    .issue        (issue),
    .id_valid     (bus.id_valid),
    .id_rs        (bus.id_rs),
    .id_rt        (bus.id_rt),
    .id_use_rs    (bus.id_use_rs),
    .id_use_rt    (bus.id_use_rt),
    .id_rd        (bus.id_rd),
    .id_reg_write (bus.id_reg_write),
    .hazard       (hazard)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DBG_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // A taken branch retires the step just like an issue does.
  always_comb begin
    state_nxt = state;
    case (state)
      DBG_RUN:  if (bus.dbg_halt_req) state_nxt = DBG_HALT;
      DBG_HALT: begin
        if (bus.dbg_step_req)                           state_nxt = DBG_STEP;
        else if (bus.dbg_resume && !bus.dbg_halt_req)   state_nxt = DBG_RUN;
      end
      DBG_STEP: if (issue || bus.ex_branch_taken) state_nxt = DBG_HALT;
      default:  state_nxt = DBG_RUN;
    endcase
  end

  always_comb begin
    bus.pc_we     = 1'b0;
    bus.fd_we     = 1'b0;
    bus.fd_flush  = 1'b0;
    bus.de_bubble = 1'b1;
    if (!rst) begin
      bus.de_bubble = 1'b1;
    end else if (bus.ex_branch_taken) begin
      bus.pc_we    = 1'b1;
      bus.fd_we    = 1'b1;
      bus.fd_flush = 1'b1;
    end else if (hazard || (state == DBG_HALT) || ((state == DBG_STEP) && !issue)) begin
      bus.de_bubble = 1'b1;
    end else begin
      bus.pc_we     = 1'b1;
      bus.fd_we     = 1'b1;
      bus.de_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (hazard && !bus.ex_branch_taken && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.dbg_state = state;
  assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a wide-counter and a 2-bit-counter instance
// share stimulus; a monitor pops expected words and compares every cycle.
module tb_hazard_stall_ctrl;

  logic clk;
  logic rst;

  hazard_stall_ctrl_if #(.CNT_W(16)) bus16 ();
  hazard_stall_ctrl_if #(.CNT_W(2))  bus2  ();

  hazard_stall_ctrl #(.SB_DEPTH(3), .CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  hazard_stall_ctrl #(.SB_DEPTH(3), .CNT_W(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));

  localparam logic [3:0] PASS  = 4'b1100;  // {pc_we, fd_we, fd_flush, de_bubble}
  localparam logic [3:0] STALL = 4'b0001;
  localparam logic [3:0] FLUSH = 4'b1111;
  localparam logic [1:0] S_RUN  = 2'b00;
  localparam logic [1:0] S_HALT = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;

  logic [21:0] exp_q[$];
  string       name_q[$];
  int          checks;
  int          failures;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b1;
    #2 rst = 1'b0;
  end

  // driver
  task automatic vec(input string nm, input logic r, input logic v,
                     input int rs, input int rt, input logic urs, input logic urt,
                     input int rd, input logic rw, input logic br,
                     input logic hq, input logic sq, input logic rq,
                     input logic [3:0] ctl, input logic [1:0] st, input int cnt);
    @(posedge clk);
    #1;
    rst = r;
    bus16.id_valid = v;         bus2.id_valid = v;
    bus16.id_rs = 5'(rs);       bus2.id_rs = 5'(rs);
    bus16.id_rt = 5'(rt);       bus2.id_rt = 5'(rt);
    bus16.id_use_rs = urs;      bus2.id_use_rs = urs;
    bus16.id_use_rt = urt;      bus2.id_use_rt = urt;
    bus16.id_rd = 5'(rd);       bus2.id_rd = 5'(rd);
    bus16.id_reg_write = rw;    bus2.id_reg_write = rw;
    bus16.ex_branch_taken = br; bus2.ex_branch_taken = br;
    bus16.dbg_halt_req = hq;    bus2.dbg_halt_req = hq;
    bus16.dbg_step_req = sq;    bus2.dbg_step_req = sq;
    bus16.dbg_resume = rq;      bus2.dbg_resume = rq;
    exp_q.push_back({ctl, st, 16'(cnt)});
    name_q.push_back(nm);
  endtask

  // scoreboard monitor
  initial begin
    logic [21:0] exp_w;
    logic [21:0] got_w;
    logic [1:0]  exp_c2;
    string       nm;
    checks   = 0;
    failures = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_w  = exp_q.pop_front();
        nm     = name_q.pop_front();
        got_w  = {bus16.pc_we, bus16.fd_we, bus16.fd_flush, bus16.de_bubble,
                  bus16.dbg_state, bus16.stall_cnt};
        exp_c2 = (exp_w[15:0] > 16'd3) ? 2'd3 : exp_w[1:0];
        checks++;
        if (got_w !== exp_w) begin
          failures++;
          $display("FAIL %s: ctl=%b state=%b cnt=%0d, required ctl=%b state=%b cnt=%0d",
                   nm, got_w[21:18], got_w[17:16], got_w[15:0],
                   exp_w[21:18], exp_w[17:16], exp_w[15:0]);
        end
        checks++;
        if (bus2.stall_cnt !== exp_c2) begin
          failures++;
          $display("FAIL %s_cnt2: stall_cnt=%0d, required %0d", nm, bus2.stall_cnt, exp_c2);
        end
      end
    end
  end

  initial begin
    //   name            r v rs rt urs urt rd rw br hq sq rq ctl    state   cnt
    vec("rst_hold",      0,0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, STALL, S_RUN,  0);
    vec("rst_branch",    0,0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, STALL, S_RUN,  0);
    // back-to-back RAW: add $3,$1,$2 ; add $4,$3,$3
    vec("t1_prod",       1,1, 1, 2, 1, 1,  3, 1, 0, 0, 0, 0, PASS,  S_RUN,  0);
    vec("t1_stall1",     1,1, 3, 3, 1, 1,  4, 1, 0, 0, 0, 0, STALL, S_RUN,  0);
    vec("t1_stall2",     1,1, 3, 3, 1, 1,  4, 1, 0, 0, 0, 0, STALL, S_RUN,  1);
    vec("t1_stall3",     1,1, 3, 3, 1, 1,  4, 1, 0, 0, 0, 0, STALL, S_RUN,  2);
    vec("t1_issue",      1,1, 3, 3, 1, 1,  4, 1, 0, 0, 0, 0, PASS,  S_RUN,  3);
    // independent adds and $0 traffic
    vec("t2_add5",       1,1, 1, 2, 1, 1,  5, 1, 0, 0, 0, 0, PASS,  S_RUN,  3);
    vec("t2_add6",       1,1, 1, 2, 1, 1,  6, 1, 0, 0, 0, 0, PASS,  S_RUN,  3);
    vec("t2_zero_prod",  1,1, 1, 2, 1, 1,  0, 1, 0, 0, 0, 0, PASS,  S_RUN,  3);
    vec("t2_zero_read",  1,1, 0, 0, 1, 1,  7, 1, 0, 0, 0, 0, PASS,  S_RUN,  3);
    // branch while hazard-stalled
    vec("t3_stall",      1,1, 7, 0, 1, 1,  8, 1, 0, 0, 0, 0, STALL, S_RUN,  3);
    vec("t3_flush",      1,1, 7, 0, 1, 1,  8, 1, 1, 0, 0, 0, FLUSH, S_RUN,  4);
    vec("t3_after",      1,0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, PASS,  S_RUN,  4);
    // debug: halt, drain, step, resume
    vec("t4_halt_req",   1,1, 1, 2, 1, 1,  9, 1, 0, 1, 0, 0, PASS,  S_RUN,  4);
    vec("t4_drain1",     1,1, 9, 9, 1, 1, 10, 1, 0, 0, 0, 0, STALL, S_HALT, 4);
    vec("t4_drain2",     1,1, 9, 9, 1, 1, 10, 1, 0, 0, 0, 0, STALL, S_HALT, 5);
    vec("t4_drain3",     1,1, 9, 9, 1, 1, 10, 1, 0, 0, 0, 0, STALL, S_HALT, 6);
    vec("t4_hold1",      1,1, 9, 9, 1, 1, 10, 1, 0, 0, 0, 0, STALL, S_HALT, 7);
    vec("t4_hold2",      1,1, 9, 9, 1, 1, 10, 1, 0, 0, 0, 0, STALL, S_HALT, 7);
    vec("t4_step_req",   1,1, 9, 9, 1, 1, 10, 1, 0, 0, 1, 0, STALL, S_HALT, 7);
    vec("t4_step_issue", 1,1, 9, 9, 1, 1, 10, 1, 0, 0, 0, 0, PASS,  S_STEP, 7);
    vec("t4_step_done",  1,1, 1, 2, 1, 1, 11, 1, 0, 0, 0, 0, STALL, S_HALT, 7);
    vec("t4_resume_blk", 1,1, 1, 2, 1, 1, 11, 1, 0, 1, 0, 1, STALL, S_HALT, 7);
    vec("t4_resume",     1,1, 1, 2, 1, 1, 11, 1, 0, 0, 0, 1, STALL, S_HALT, 7);
    vec("t4_run",        1,1, 1, 2, 1, 1, 11, 1, 0, 0, 0, 0, PASS,  S_RUN,  7);
    // reset mid-stall with two valid slots
    vec("t5_prod",       1,1, 1, 2, 1, 1, 12, 1, 0, 0, 0, 0, PASS,  S_RUN,  7);
    vec("t5_stall",      1,1,12,11, 1, 1, 13, 1, 0, 0, 0, 0, STALL, S_RUN,  7);
    vec("t5_rst",        0,1,12,11, 1, 1, 13, 1, 0, 0, 0, 0, STALL, S_RUN,  0);
    vec("t5_release",    1,1,12,11, 1, 1, 13, 1, 0, 0, 0, 0, PASS,  S_RUN,  0);
    // five stall cycles: 2-bit counter saturates at 3
    vec("t6_stall1",     1,1,13, 0, 1, 0, 14, 1, 0, 0, 0, 0, STALL, S_RUN,  0);
    vec("t6_stall2",     1,1,13, 0, 1, 0, 14, 1, 0, 0, 0, 0, STALL, S_RUN,  1);
    vec("t6_stall3",     1,1,13, 0, 1, 0, 14, 1, 0, 0, 0, 0, STALL, S_RUN,  2);
    vec("t6_issue1",     1,1,13, 0, 1, 0, 14, 1, 0, 0, 0, 0, PASS,  S_RUN,  3);
    vec("t6_gap",        1,0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, PASS,  S_RUN,  3);
    vec("t6_stall4",     1,1,14, 0, 1, 0, 15, 1, 0, 0, 0, 0, STALL, S_RUN,  3);
    vec("t6_stall5",     1,1,14, 0, 1, 0, 15, 1, 0, 0, 0, 0, STALL, S_RUN,  4);
    vec("t6_issue2",     1,1,14, 0, 1, 0, 15, 1, 0, 0, 0, 0, PASS,  S_RUN,  5);
    vec("t6_final",      1,0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, PASS,  S_RUN,  5);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout: pending=%0d, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
